// File: rtl/ifetch_queue_pkg.sv
// Shared fetch-path types: instruction bus request/response and buffered fetch entries.
package ifetch_queue_pkg;
  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;

  localparam addr_t       RESET_PC_DEFAULT = 32'hbfc0_0000;
  localparam int unsigned INSTR_BYTES      = 4;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } ibus_resp_t;

  typedef struct packed {
    addr_t pc;
    word_t instr;
  } fetch_entry_t;
endpackage

// File: rtl/ifetch_fifo.sv
// First-word-fall-through FIFO with synchronous clear; a full FIFO accepts a push when popped in the same cycle.
module ifetch_fifo
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = fetch_entry_t
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         push,
  input  T                             din,
  input  logic                         pop,
  input  logic                         clear,
  output T                             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  T               mem [DEPTH];
  logic [PW-1:0]  rd_ptr, wr_ptr;
  logic           do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/ifetch_queue.sv
// Pipelined instruction fetch: credit-limited in-order ibus requests feeding a PC-tagged
// decode buffer, with redirect flush and drop counting for stale in-flight responses.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned MAX_INFLIGHT = 2,
  parameter addr_t       RESET_PC     = RESET_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       resetn,
  output ibus_req_t  ireq,
  input  ibus_resp_t iresp,
  input  logic       redirect_valid,
  input  addr_t      redirect_pc,
  output logic       out_valid,
  output addr_t      out_pc,
  output word_t      out_instr,
  input  logic       out_ready
);
  localparam int unsigned IW = $clog2(MAX_INFLIGHT + 2);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic {IDLE, REQ} state_t;

  state_t          state;
  addr_t           fetch_pc, req_addr, fetch_pc_next, resp_pc;
  logic [IW-1:0]   inflight, drop, inflight_next;
  logic            stale;
  logic            addr_fire, data_fire, buf_push, buf_pop, credit;
  logic            buf_full, buf_empty, af_full, af_empty;
  logic [CW-1:0]   buf_count, cnt_next;
  logic [AW-1:0]   af_count;
  fetch_entry_t    push_entry, head;

  assign addr_fire     = (state == REQ) && iresp.addr_ok;
  assign data_fire     = iresp.data_ok;
  assign inflight_next = inflight + IW'(addr_fire) - IW'(data_fire);
  assign buf_push      = data_fire && (drop == '0) && !redirect_valid;
  assign buf_pop       = out_valid && out_ready && !redirect_valid;
  assign cnt_next      = redirect_valid ? '0 : buf_count + CW'(buf_push) - CW'(buf_pop);
  // Credit uses post-edge occupancy so an accepted request can be followed immediately.
  assign credit        = (32'(inflight_next) + 32'(cnt_next) + 32'd1 <= DEPTH) &&
                         (32'(inflight_next) < MAX_INFLIGHT);

  always_comb begin
    fetch_pc_next = fetch_pc;
    if (redirect_valid)          fetch_pc_next = redirect_pc;
    else if (addr_fire && !stale) fetch_pc_next = fetch_pc + INSTR_BYTES;
  end

  always_comb begin
    ireq.valid = (state == REQ);
    ireq.addr  = (state == REQ) ? req_addr : fetch_pc;
  end

  assign push_entry = '{pc: resp_pc, instr: iresp.data};
  assign out_valid  = !buf_empty;
  assign out_pc     = head.pc;
  assign out_instr  = head.instr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
      stale    <= 1'b0;
    end else begin
      inflight <= inflight_next;
      fetch_pc <= fetch_pc_next;
      // A request caught mid-handshake by a redirect completes later and is dropped then.
      if (redirect_valid)
        drop <= inflight_next;
      else
        drop <= drop - IW'(data_fire && (drop != '0)) + IW'(addr_fire && stale);
      if ((state == REQ) && !iresp.addr_ok && redirect_valid) stale <= 1'b1;
      else if (addr_fire)                                    stale <= 1'b0;
      if ((state == IDLE) || addr_fire) begin
        state    <= credit ? REQ : IDLE;
        req_addr <= fetch_pc_next;
      end
    end
  end

  ifetch_fifo #(.DEPTH(MAX_INFLIGHT), .T(addr_t)) u_addr_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (addr_fire),
    .din    (req_addr),
    .pop    (data_fire),
    .clear  (1'b0),
    .dout   (resp_pc),
    .full   (af_full),
    .empty  (af_empty),
    .count  (af_count)
  );

  ifetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_buf (
    .clk    (clk),
    .resetn (resetn),
    .push   (buf_push),
    .din    (push_entry),
    .pop    (buf_pop),
    .clear  (redirect_valid),
    .dout   (head),
    .full   (buf_full),
    .empty  (buf_empty),
    .count  (buf_count)
  );

  a_no_push_full: assert property (@(posedge clk) disable iff (!resetn)
    !(buf_push && buf_full && !buf_pop));
  a_no_data_idle: assert property (@(posedge clk) disable iff (!resetn)
    !(iresp.data_ok && (inflight == '0) && af_empty));
  a_addr_stable:  assert property (@(posedge clk) disable iff (!resetn)
    (ireq.valid && !iresp.addr_ok) |=> (ireq.valid && $stable(ireq.addr)));
  a_af_track:     assert property (@(posedge clk) disable iff (!resetn)
    (32'(af_count) == 32'(inflight)) && !(addr_fire && af_full));
endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: a latency-configurable memory model queues expected
// {pc, instr} entries on each accepted request; the decode-side monitor pops and compares.
module tb_ifetch_queue;
  import ifetch_queue_pkg::*;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  logic       redirect_valid = 1'b0;
  addr_t      redirect_pc = '0;
  logic       out_valid;
  addr_t      out_pc;
  word_t      out_instr;
  logic       out_ready = 1'b1;

  int checks = 0, errors = 0;
  fetch_entry_t sb[$];
  addr_t        pend_addr[$];
  int           pend_rdy[$];
  int           cyc = 0, mem_lat = 1, accepts = 0, stale_cnt = 0;
  logic         addr_ok_en = 1'b1;
  addr_t        exp_pc = 32'hbfc0_0000, last_acc = '0;
  fetch_entry_t mon_e, acc_e;

  always #5 clk = ~clk;

  ifetch_queue #(.DEPTH(4), .MAX_INFLIGHT(2), .RESET_PC(32'hbfc0_0000)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .ireq           (ireq),
    .iresp          (iresp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_ready      (out_ready)
  );

  function automatic word_t mem_word(input addr_t a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  // Memory drive: responds off stable registered request state.
  initial begin
    iresp = '0;
    forever begin
      @(posedge clk); #2;
      iresp.addr_ok = ireq.valid && addr_ok_en;
      iresp.data_ok = resetn && (pend_addr.size() > 0) && (pend_rdy[0] <= cyc);
      iresp.data    = iresp.data_ok ? mem_word(pend_addr[0]) : 32'h0;
    end
  end

  // Handshake bookkeeping and decode-side scoreboard compare, ahead of each posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (!resetn) begin
        sb.delete(); pend_addr.delete(); pend_rdy.delete();
        exp_pc = 32'hbfc0_0000;
      end else begin
        if (out_valid && out_ready && !redirect_valid) begin
          checks++;
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_pop: got pc=%h instr=%h, expected queue empty", out_pc, out_instr);
          end else begin
            mon_e = sb.pop_front();
            if (out_pc !== mon_e.pc || out_instr !== mon_e.instr) begin
              errors++;
              $display("FAIL sb_entry: got pc=%h instr=%h, expected pc=%h instr=%h",
                       out_pc, out_instr, mon_e.pc, mon_e.instr);
            end
          end
        end
        if (redirect_valid) begin
          sb.delete();
          exp_pc = redirect_pc;
        end
        if (iresp.data_ok) begin
          void'(pend_addr.pop_front());
          void'(pend_rdy.pop_front());
        end
        if (ireq.valid && iresp.addr_ok) begin
          accepts++;
          last_acc = ireq.addr;
          pend_addr.push_back(ireq.addr);
          pend_rdy.push_back(cyc + mem_lat);
          if (ireq.addr == exp_pc) begin
            acc_e.pc = ireq.addr;
            acc_e.instr = mem_word(ireq.addr);
            sb.push_back(acc_e);
            exp_pc = exp_pc + 32'd4;
          end else begin
            stale_cnt++;
          end
        end
      end
      cyc++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (2) tick();
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    mem_lat = 1; addr_ok_en = 1'b1; out_ready = 1'b1;
    #1 resetn = 1'b0;
    repeat (2) tick();
    checks += 3;
    if (ireq.valid !== 1'b0) begin errors++; $display("FAIL rst_ivalid: got %b, expected 0", ireq.valid); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_ovalid: got %b, expected 0", out_valid); end
    if (ireq.addr !== 32'hbfc0_0000) begin errors++; $display("FAIL rst_addr: got %h, expected bfc00000", ireq.addr); end
    resetn = 1'b1;
    tick();
    checks++;
    if (ireq.valid !== 1'b1 || ireq.addr !== 32'hbfc0_0000) begin
      errors++; $display("FAIL first_req: got valid=%b addr=%h, expected 1/bfc00000", ireq.valid, ireq.addr);
    end
  endtask

  task automatic test_stream();
    int vcount;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL startup_c2: got out_valid=%b, expected 0", out_valid); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'hbfc0_0000) begin
      errors++; $display("FAIL startup_c3: got valid=%b pc=%h, expected 1/bfc00000", out_valid, out_pc);
    end
    vcount = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (out_valid === 1'b1) vcount++;
    end
    checks += 2;
    if (vcount != 12) begin errors++; $display("FAIL throughput: got %0d valid cycles, expected 12", vcount); end
    if (stale_cnt != 0) begin errors++; $display("FAIL stream_seq: got %0d out-of-order requests, expected 0", stale_cnt); end
  endtask

  task automatic test_backpressure();
    int busy, n, a0;
    out_ready = 1'b0; mem_lat = 1;
    do_reset();
    busy = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i >= 10 && ireq.valid !== 1'b0) busy++;
    end
    checks += 4;
    if (sb.size() != 4) begin errors++; $display("FAIL bp_count: got %0d buffered, expected 4", sb.size()); end
    if (pend_addr.size() != 0) begin errors++; $display("FAIL bp_inflight: got %0d pending, expected 0", pend_addr.size()); end
    if (busy != 0) begin errors++; $display("FAIL bp_ivalid: got %0d request cycles, expected 0", busy); end
    if (out_valid !== 1'b1 || out_pc !== 32'hbfc0_0000) begin
      errors++; $display("FAIL bp_head: got valid=%b pc=%h, expected 1/bfc00000", out_valid, out_pc);
    end
    a0 = accepts; n = 0;
    out_ready = 1'b1;
    while (accepts == a0 && n < 20) begin tick(); n++; end
    checks++;
    if (n >= 20 || last_acc !== 32'hbfc0_0010) begin
      errors++; $display("FAIL bp_resume: got addr=%h after %0d cycles, expected bfc00010", last_acc, n);
    end
    repeat (8) tick();
  endtask

  task automatic test_addr_stall();
    int s0;
    addr_ok_en = 1'b0; out_ready = 1'b1; mem_lat = 1;
    do_reset();
    tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (ireq.valid !== 1'b1 || ireq.addr !== 32'hbfc0_0000) begin
        errors++; $display("FAIL stall_c%0d: got valid=%b addr=%h, expected 1/bfc00000", i, ireq.valid, ireq.addr);
      end
    end
    s0 = stale_cnt;
    addr_ok_en = 1'b1;
    repeat (12) tick();
    checks++;
    if (stale_cnt != s0 || accepts == 0) begin
      errors++; $display("FAIL stall_dup: got %0d unexpected requests, expected 0", stale_cnt - s0);
    end
  endtask

  task automatic wait_first_out(input addr_t pc, input string name);
    int n = 0;
    while (out_valid !== 1'b1 && n < 40) begin tick(); n++; end
    checks++;
    if (n >= 40 || out_pc !== pc) begin
      errors++; $display("FAIL %s: got valid=%b pc=%h after %0d cycles, expected pc=%h", name, out_valid, out_pc, n, pc);
    end
  endtask

  task automatic test_redirect();
    int n = 0;
    mem_lat = 4; out_ready = 1'b1; addr_ok_en = 1'b1;
    while (pend_addr.size() != 2 && n < 30) begin tick(); n++; end
    checks++;
    if (n >= 30) begin errors++; $display("FAIL rd_inflight: got %0d pending, expected 2", pend_addr.size()); end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rd_flush: got out_valid=%b, expected 0", out_valid); end
    wait_first_out(32'h8000_1000, "rd_first");
    repeat (6) tick();
  endtask

  task automatic test_redirect_pending();
    addr_t a0;
    int s0, n = 0;
    mem_lat = 1; out_ready = 1'b1;
    addr_ok_en = 1'b0;
    while (ireq.valid !== 1'b1 && n < 20) begin tick(); n++; end
    repeat (2) tick();
    a0 = ireq.addr; s0 = stale_cnt;
    redirect_valid = 1'b1; redirect_pc = 32'h8000_2000;
    tick();
    redirect_valid = 1'b0;
    repeat (2) tick();
    checks++;
    if (ireq.valid !== 1'b1 || ireq.addr !== a0) begin
      errors++; $display("FAIL rp_hold: got valid=%b addr=%h, expected 1/%h", ireq.valid, ireq.addr, a0);
    end
    addr_ok_en = 1'b1;
    wait_first_out(32'h8000_2000, "rp_first");
    checks++;
    if (stale_cnt != s0 + 1) begin errors++; $display("FAIL rp_stale: got %0d stale requests, expected 1", stale_cnt - s0); end
    repeat (6) tick();
  endtask

  task automatic test_redirect_full();
    int n = 0;
    mem_lat = 3; out_ready = 1'b0;
    tick(); #2;
    while (!(iresp.data_ok === 1'b1 && sb.size() == 4 && pend_addr.size() == 1) && n < 40) begin
      tick(); #2; n++;
    end
    checks++;
    if (n >= 40) begin errors++; $display("FAIL rf_setup: got buffered=%0d pending=%0d, expected 4/1", sb.size(), pend_addr.size()); end
    redirect_valid = 1'b1; redirect_pc = 32'h8000_3000; out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rf_empty: got out_valid=%b, expected 0", out_valid); end
    wait_first_out(32'h8000_3000, "rf_first");
    repeat (6) tick();
  endtask

  task automatic test_reset_midstream();
    int a0, n = 0;
    mem_lat = 3; out_ready = 1'b1;
    while (pend_addr.size() != 2 && n < 30) begin tick(); n++; end
    resetn = 1'b0;
    #1;
    checks += 3;
    if (ireq.valid !== 1'b0) begin errors++; $display("FAIL mr_ivalid: got %b, expected 0", ireq.valid); end
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_ovalid: got %b, expected 0", out_valid); end
    if (ireq.addr !== 32'hbfc0_0000) begin errors++; $display("FAIL mr_addr: got %h, expected bfc00000", ireq.addr); end
    a0 = accepts;
    repeat (2) tick();
    resetn = 1'b1;
    n = 0;
    while (accepts == a0 && n < 20) begin tick(); n++; end
    checks++;
    if (n >= 20 || last_acc !== 32'hbfc0_0000) begin
      errors++; $display("FAIL mr_first: got addr=%h after %0d cycles, expected bfc00000", last_acc, n);
    end
    repeat (15) tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_addr_stall();
    test_redirect();
    test_redirect_pending();
    test_redirect_full();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
